// File: rtl/if_fetch_stage.sv
// ---------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction fetch stage feeding the decode (ID) stage.
//   * Owns the program counter and issues at most one instruction-memory
//     request at a time (request / grant / response handshake).
//   * Drives the IF/ID pipeline register (id_pc, id_inst, id_valid).
//   * Honours a decode stall (rest_from_id) by holding IF/ID and parking a
//     response that arrives during the stall in a one-entry buffer.
//   * Honours an EX redirect (jump_en / jump_pc) by flushing IF/ID, dropping
//     any parked instruction and discarding a response that is still in
//     flight.
//
// Ports
//   clk           in   clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   rest_from_id  in   decode stall, IF/ID holds
//   jump_en       in   redirect from EX
//   jump_pc       in   redirect target (bits [1:0] ignored)
//   imem_req      out  fetch request valid
//   imem_addr     out  fetch address
//   imem_gnt      in   request accepted this cycle
//   imem_rvalid   in   response valid
//   imem_rdata    in   fetched instruction
//   id_pc         out  PC of instruction in IF/ID
//   id_inst       out  instruction in IF/ID
//   id_valid      out  IF/ID holds a real instruction
// ---------------------------------------------------------------------------
module if_fetch_stage #(
    parameter int                   PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = 64'h8000_0000,
    parameter logic [31:0]          NOP_INST = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rest_from_id,
    input  logic                jump_en,
    input  logic [PC_WIDTH-1:0] jump_pc,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic [PC_WIDTH-1:0] id_pc,
    output logic [31:0]         id_inst,
    output logic                id_valid
);

    // FETCH : request outstanding on the bus, waiting for a grant
    // WAIT  : granted, waiting for the single response
    // HOLD  : response parked in the buffer because decode is stalled;
    //         being in HOLD is what marks the buffer as occupied
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_reg,       state_next;
    logic [PC_WIDTH-1:0]   pc_reg,          pc_next;
    logic [PC_WIDTH-1:0]   inflight_pc_reg, inflight_pc_next;
    logic                  kill_reg,        kill_next;
    logic [PC_WIDTH-1:0]   buf_pc_reg,      buf_pc_next;
    logic [31:0]           buf_inst_reg,    buf_inst_next;
    logic [PC_WIDTH-1:0]   id_pc_reg,       id_pc_next;
    logic [31:0]           id_inst_reg,     id_inst_next;
    logic                  id_valid_reg,    id_valid_next;

    // An instruction that is ready to enter IF/ID this cycle
    logic                  load_avail;
    logic [PC_WIDTH-1:0]   load_pc;
    logic [31:0]           load_inst;

    logic [PC_WIDTH-1:0]   jump_pc_aligned;

    assign jump_pc_aligned = {jump_pc[PC_WIDTH-1:2], 2'b00};

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        inflight_pc_next = inflight_pc_reg;
        kill_next        = kill_reg;
        buf_pc_next      = buf_pc_reg;
        buf_inst_next    = buf_inst_reg;
        load_avail       = 1'b0;
        load_pc          = inflight_pc_reg;
        load_inst        = imem_rdata;

        case (state_reg)
            FETCH: begin
                if (imem_gnt) begin
                    inflight_pc_next = pc_reg;
                    // Natural wrap modulo 2^PC_WIDTH
                    pc_next          = pc_reg + PC_WIDTH'(4);
                    state_next       = WAIT;
                end
            end

            WAIT: begin
                if (imem_rvalid) begin
                    if (kill_reg) begin
                        // Response belongs to a squashed fetch
                        kill_next  = 1'b0;
                        state_next = FETCH;
                    end else if (!rest_from_id) begin
                        load_avail = 1'b1;
                        load_pc    = inflight_pc_reg;
                        load_inst  = imem_rdata;
                        state_next = FETCH;
                    end else begin
                        buf_pc_next   = inflight_pc_reg;
                        buf_inst_next = imem_rdata;
                        state_next    = HOLD;
                    end
                end
            end

            HOLD: begin
                if (!rest_from_id) begin
                    load_avail = 1'b1;
                    load_pc    = buf_pc_reg;
                    load_inst  = buf_inst_reg;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase

        // Redirect overrides everything above.
        if (jump_en) begin
            pc_next    = jump_pc_aligned;
            load_avail = 1'b0;
            case (state_reg)
                FETCH: begin
                    // A grant in the same cycle still launches a request on
                    // the bus; its response has to be thrown away, and the
                    // grant must not advance the new PC.
                    if (imem_gnt) begin
                        kill_next  = 1'b1;
                        state_next = WAIT;
                    end else begin
                        state_next = FETCH;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        // Response arrives together with the redirect:
                        // drop it now, nothing left in flight.
                        kill_next  = 1'b0;
                        state_next = FETCH;
                    end else begin
                        kill_next  = 1'b1;
                        state_next = WAIT;
                    end
                end
                default: begin
                    // HOLD: parked instruction is on the wrong path
                    state_next = FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register update: flush > stall hold > load > bubble
    // ------------------------------------------------------------------
    always_comb begin
        id_pc_next    = id_pc_reg;
        id_inst_next  = id_inst_reg;
        id_valid_next = id_valid_reg;

        if (jump_en) begin
            id_inst_next  = NOP_INST;
            id_valid_next = 1'b0;
        end else if (rest_from_id) begin
            id_pc_next    = id_pc_reg;
            id_inst_next  = id_inst_reg;
            id_valid_next = id_valid_reg;
        end else if (load_avail) begin
            id_pc_next    = load_pc;
            id_inst_next  = load_inst;
            id_valid_next = 1'b1;
        end else begin
            id_inst_next  = NOP_INST;
            id_valid_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= FETCH;
            pc_reg          <= RESET_PC;
            inflight_pc_reg <= '0;
            kill_reg        <= 1'b0;
            buf_pc_reg      <= '0;
            buf_inst_reg    <= NOP_INST;
            id_pc_reg       <= '0;
            id_inst_reg     <= NOP_INST;
            id_valid_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            inflight_pc_reg <= inflight_pc_next;
            kill_reg        <= kill_next;
            buf_pc_reg      <= buf_pc_next;
            buf_inst_reg    <= buf_inst_next;
            id_pc_reg       <= id_pc_next;
            id_inst_reg     <= id_inst_next;
            id_valid_reg    <= id_valid_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Qualified with rst_n so no request is visible while reset is held,
    // even though the state register already sits in FETCH.
    assign imem_req  = rst_n && (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign id_pc     = id_pc_reg;
    assign id_inst   = id_inst_reg;
    assign id_valid  = id_valid_reg;

endmodule
